// File: rtl/draw_bouncing_rect.sv
// draw_bouncing_rect: pixel stage behind the 800x600 VGA timing generator.
// It draws a background, a one-pixel screen border and a solid rectangle.
// The rectangle moves once per frame during vertical blank and bounces off
// the active-area edges. Timing signals are delayed to line up with rgb_out.
module draw_bouncing_rect #(
    parameter int unsigned H_ACTIVE     = 800,
    parameter int unsigned V_ACTIVE     = 600,
    parameter int unsigned RECT_W       = 64,
    parameter int unsigned RECT_H       = 48,
    parameter int unsigned STEP         = 2,
    parameter int unsigned X0           = 100,
    parameter int unsigned Y0           = 80,
    parameter logic [11:0] RECT_COLOR   = 12'hF00,
    parameter logic [11:0] BORDER_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR     = 12'h08F
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    typedef enum logic [1:0] {
        CLS_BLANK  = 2'd0,
        CLS_RECT   = 2'd1,
        CLS_BORDER = 2'd2,
        CLS_BG     = 2'd3
    } region_e;

    localparam logic [11:0] H_ACT_12 = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_12 = 12'(V_ACTIVE);
    localparam logic [11:0] RW_12    = 12'(RECT_W);
    localparam logic [11:0] RH_12    = 12'(RECT_H);
    localparam logic [11:0] STEP_12  = 12'(STEP);
    localparam logic [10:0] STEP_11  = 11'(STEP);
    localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - RECT_W);
    localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - RECT_H);
    localparam logic [10:0] H_LAST   = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_LAST   = 11'(V_ACTIVE - 1);
    localparam logic [10:0] X_RST    = 11'(X0);
    localparam logic [10:0] Y_RST    = 11'(Y0);

    // Rectangle position/direction state
    logic [10:0] x_pos_q, x_pos_d;
    logic [10:0] y_pos_q, y_pos_d;
    logic        dx_q, dx_d;
    logic        dy_q, dy_d;
    logic        vblnk_prev_q;

    // Stage 1 pipeline registers
    logic [10:0] hcount_q, vcount_q;
    logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
    region_e     class_q, class_d;

    logic        frame_tick_s;
    logic [11:0] x_sum_s, y_sum_s;
    logic [11:0] h12_s, v12_s, xp12_s, yp12_s;
    logic        in_rect_s, on_border_s;

    // Rising edge of vertical blank marks the start of a new frame
    assign frame_tick_s = vblnk_in & ~vblnk_prev_q;

    // Next position and direction: both axes step and bounce independently
    always_comb begin
        x_pos_d = x_pos_q;
        y_pos_d = y_pos_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        x_sum_s = {1'b0, x_pos_q} + STEP_12;
        y_sum_s = {1'b0, y_pos_q} + STEP_12;
        if (frame_tick_s && enable) begin
            if (!dx_q) begin
                if ((x_sum_s + RW_12) > H_ACT_12) begin
                    x_pos_d = X_MAX;
                    dx_d    = 1'b1;
                end else begin
                    x_pos_d = x_sum_s[10:0];
                end
            end else begin
                if (x_pos_q < STEP_11) begin
                    x_pos_d = 11'd0;
                    dx_d    = 1'b0;
                end else begin
                    x_pos_d = x_pos_q - STEP_11;
                end
            end
            if (!dy_q) begin
                if ((y_sum_s + RH_12) > V_ACT_12) begin
                    y_pos_d = Y_MAX;
                    dy_d    = 1'b1;
                end else begin
                    y_pos_d = y_sum_s[10:0];
                end
            end else begin
                if (y_pos_q < STEP_11) begin
                    y_pos_d = 11'd0;
                    dy_d    = 1'b0;
                end else begin
                    y_pos_d = y_pos_q - STEP_11;
                end
            end
        end else begin
            x_pos_d = x_pos_q;
        end
    end

    // Position registers; the reset value of vblnk_prev suppresses a false tick
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            x_pos_q      <= X_RST;
            y_pos_q      <= Y_RST;
            dx_q         <= 1'b0;
            dy_q         <= 1'b0;
            vblnk_prev_q <= 1'b1;
        end else begin
            x_pos_q      <= x_pos_d;
            y_pos_q      <= y_pos_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            vblnk_prev_q <= vblnk_in;
        end
    end

    // Classify the incoming pixel; 12-bit compares keep x_pos+RECT_W from wrapping
    always_comb begin
        h12_s       = {1'b0, hcount_in};
        v12_s       = {1'b0, vcount_in};
        xp12_s      = {1'b0, x_pos_q};
        yp12_s      = {1'b0, y_pos_q};
        in_rect_s   = (h12_s >= xp12_s) && (h12_s < (xp12_s + RW_12)) &&
                      (v12_s >= yp12_s) && (v12_s < (yp12_s + RH_12));
        on_border_s = (hcount_in == 11'd0) || (hcount_in == H_LAST) ||
                      (vcount_in == 11'd0) || (vcount_in == V_LAST);
        if (hblnk_in || vblnk_in) begin
            class_d = CLS_BLANK;
        end else if (in_rect_s) begin
            class_d = CLS_RECT;
        end else if (on_border_s) begin
            class_d = CLS_BORDER;
        end else begin
            class_d = CLS_BG;
        end
    end

    // Stage 1: capture timing inputs together with the region class
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_q <= 11'd0;
            vcount_q <= 11'd0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            class_q  <= CLS_BLANK;
        end else begin
            hcount_q <= hcount_in;
            vcount_q <= vcount_in;
            hsync_q  <= hsync_in;
            vsync_q  <= vsync_in;
            hblnk_q  <= hblnk_in;
            vblnk_q  <= vblnk_in;
            class_q  <= class_d;
        end
    end

    // Stage 2: delay timing once more and turn the class into a colour
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'h000;
        end else begin
            hcount_out <= hcount_q;
            vcount_out <= vcount_q;
            hsync_out  <= hsync_q;
            vsync_out  <= vsync_q;
            hblnk_out  <= hblnk_q;
            vblnk_out  <= vblnk_q;
            case (class_q)
                CLS_BLANK:  rgb_out <= 12'h000;
                CLS_RECT:   rgb_out <= RECT_COLOR;
                CLS_BORDER: rgb_out <= BORDER_COLOR;
                CLS_BG:     rgb_out <= BG_COLOR;
                default:    rgb_out <= 12'h000;
            endcase
        end
    end

endmodule
